fetch_ctrl: RTL and testbench

//   Step-1 fetch stage and PC owner. Reads instruction memory at the current PC and registers
//   the instruction, with its PC, into step 1. Uses the branch-detect flags from steps 2-4 to

---
 rtl/fetch_ctrl.sv | 73 +++++++
 tb/tb_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Step-1 fetch stage and PC owner: registers imem data into step 1, freezes fetch while a
// beq/j is in flight, injects NOP bubbles and redirects the PC when the branch resolves.
module fetch_ctrl #(
   parameter int unsigned          PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
   parameter logic [31:0]          NOP_INSTR = 32'h0000_0000,
   parameter int unsigned          CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 is_branch,
   input  logic                 is_branch_step_4,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 ext_stall,
   input  logic [31:0]          imem_data,
   output logic [PC_WIDTH-1:0]  imem_addr,
   output logic [31:0]          instr_step_1,
   output logic [PC_WIDTH-1:0]  pc_step_1,
   output logic                 valid_step_1,
   output logic                 redirect,
   output logic [CNT_WIDTH-1:0] bubble_cnt
);

   typedef enum logic [0:0] {StRun, StHold} state_e;

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;

   assign imem_addr = pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StRun;
         pc_q         <= RESET_PC;
         instr_step_1 <= NOP_INSTR;
         pc_step_1    <= '0;
         valid_step_1 <= 1'b0;
         redirect     <= 1'b0;
         bubble_cnt   <= '0;
      end else begin
         redirect <= 1'b0;
         if (!ext_stall) begin
            if (is_branch_step_4) begin
               // Resolve: pc already points at branch+4, so not-taken simply keeps it.
               if (branch_taken) begin
                  pc_q <= {branch_target[PC_WIDTH-1:2], 2'b00};
               end
               redirect     <= 1'b1;
               instr_step_1 <= NOP_INSTR;
               valid_step_1 <= 1'b0;
               state_q      <= StRun;
               if (bubble_cnt != '1) begin
                  bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
               end
            end else if (state_q == StHold || is_branch) begin
               instr_step_1 <= NOP_INSTR;
               valid_step_1 <= 1'b0;
               state_q      <= StHold;
               if (bubble_cnt != '1) begin
                  bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
               end
            end else begin
               instr_step_1 <= imem_data;
               pc_step_1    <= pc_q;
               valid_step_1 <= 1'b1;
               pc_q         <= pc_q + PC_WIDTH'(4);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: main instance at RESET_PC=0, second instance near the top of
// the address space with a 2-bit bubble counter for wrap and saturation.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        rst2;
   logic        is_branch;
   logic        is_branch_step_4;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        ext_stall;

   logic [31:0] imem_data,    imem_addr,    instr_step_1,  pc_step_1;
   logic        valid_step_1, redirect;
   logic [15:0] bubble_cnt;

   logic [31:0] imem_data2,   imem_addr2,   instr_step_12, pc_step_12;
   logic        valid_step_12, redirect2;
   logic [1:0]  bubble_cnt2;

   int checks;
   int errors;

   // Instruction memory model: word content derived from its address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_data  = mem(imem_addr);
   assign imem_data2 = mem(imem_addr2);

   fetch_ctrl u_dut (
      .clk              (clk),
      .rst              (rst),
      .is_branch        (is_branch),
      .is_branch_step_4 (is_branch_step_4),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .ext_stall        (ext_stall),
      .imem_data        (imem_data),
      .imem_addr        (imem_addr),
      .instr_step_1     (instr_step_1),
      .pc_step_1        (pc_step_1),
      .valid_step_1     (valid_step_1),
      .redirect         (redirect),
      .bubble_cnt       (bubble_cnt)
   );

   fetch_ctrl #(
      .RESET_PC  (32'hFFFF_FFFC),
      .CNT_WIDTH (2)
   ) u_dut2 (
      .clk              (clk),
      .rst              (rst2),
      .is_branch        (is_branch),
      .is_branch_step_4 (is_branch_step_4),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .ext_stall        (ext_stall),
      .imem_data        (imem_data2),
      .imem_addr        (imem_addr2),
      .instr_step_1     (instr_step_12),
      .pc_step_1        (pc_step_12),
      .valid_step_1     (valid_step_12),
      .redirect         (redirect2),
      .bubble_cnt       (bubble_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_branch();
      is_branch        = 1'b0;
      is_branch_step_4 = 1'b0;
      branch_taken     = 1'b0;
      branch_target    = '0;
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      rst2 = 1'b0;
      ext_stall = 1'b0;
      clear_branch();
      #12;
      checks++; if (imem_addr !== 32'h0) begin errors++;
         $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
      checks++; if (valid_step_1 !== 1'b0 || redirect !== 1'b0 || bubble_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_flags got v=%b r=%b c=%0d want 0 0 0",
                            valid_step_1, redirect, bubble_cnt); end
      checks++; if (instr_step_1 !== 32'h0 || pc_step_1 !== 32'h0) begin errors++;
         $display("FAIL reset_step1 got %h/%h want 0/0", instr_step_1, pc_step_1); end
      checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++;
         $display("FAIL reset_pc2 got %h want fffffffc", imem_addr2); end
      tick();
      rst  = 1'b1;
      rst2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (instr_step_1 !== mem(32'(i * 4)) || pc_step_1 !== 32'(i * 4) ||
             valid_step_1 !== 1'b1) begin
            errors++;
            $display("FAIL seq_fetch%0d got %h/%h/%b want %h/%h/1", i, instr_step_1,
                     pc_step_1, valid_step_1, mem(32'(i * 4)), 32'(i * 4));
         end
         if (i == 0) begin
            checks++;
            if (pc_step_12 !== 32'hFFFF_FFFC || imem_addr2 !== 32'h0) begin errors++;
               $display("FAIL pc_wrap got %h/%h want fffffffc/0", pc_step_12, imem_addr2); end
         end
      end
   endtask

   // Bubbles in steps 2-4 followed by the resolve cycle; pc_after is the expected redirect pc.
   task automatic run_branch(input string nm, input logic taken, input logic [31:0] tgt,
                             input logic [31:0] br_pc, input logic [31:0] pc_after);
      is_branch = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) begin
            is_branch_step_4 = 1'b1;
            branch_taken     = taken;
            branch_target    = tgt;
         end
         tick();
         checks++;
         if (valid_step_1 !== 1'b0 || instr_step_1 !== 32'h0 || bubble_cnt !== 16'(i)) begin
            errors++;
            $display("FAIL %s_bubble%0d got v=%b i=%h c=%0d want 0 0 %0d", nm, i,
                     valid_step_1, instr_step_1, bubble_cnt, i);
         end
         if (i < 3) begin
            checks++;
            if (imem_addr !== br_pc + 32'd4 || redirect !== 1'b0) begin errors++;
               $display("FAIL %s_hold%0d got pc=%h r=%b want %h 0", nm, i, imem_addr,
                        redirect, br_pc + 32'd4); end
         end
      end
      checks++;
      if (redirect !== 1'b1 || imem_addr !== pc_after) begin errors++;
         $display("FAIL %s_redirect got r=%b pc=%h want 1 %h", nm, redirect, imem_addr,
                  pc_after); end
      clear_branch();
      tick();
      checks++;
      if (pc_step_1 !== pc_after || valid_step_1 !== 1'b1 || instr_step_1 !== mem(pc_after)
          || redirect !== 1'b0) begin
         errors++;
         $display("FAIL %s_resume got %h/%b/%h r=%b want %h/1/%h r=0", nm, pc_step_1,
                  valid_step_1, instr_step_1, redirect, pc_after, mem(pc_after));
      end
   endtask

   task automatic test_taken();
      tick();
      tick();
      checks++; if (pc_step_1 !== 32'h10) begin errors++;
         $display("FAIL taken_setup got %h want 10", pc_step_1); end
      run_branch("taken", 1'b1, 32'h43, 32'h10, 32'h40);
   endtask

   task automatic test_not_taken();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (pc_step_1 !== 32'h10 || bubble_cnt !== 16'd0) begin errors++;
         $display("FAIL nt_setup got %h c=%0d want 10 c=0", pc_step_1, bubble_cnt); end
      run_branch("not_taken", 1'b0, 32'h80, 32'h10, 32'h14);
   endtask

   task automatic test_saturate();
      checks++; if (bubble_cnt2 !== 2'd3) begin errors++;
         $display("FAIL cnt_saturate got %0d want 3", bubble_cnt2); end
   endtask

   task automatic test_stall();
      is_branch = 1'b1;
      tick();
      checks++; if (valid_step_1 !== 1'b0 || bubble_cnt !== 16'd4) begin errors++;
         $display("FAIL stall_hold got v=%b c=%0d want 0 4", valid_step_1, bubble_cnt); end
      is_branch_step_4 = 1'b1;
      branch_taken     = 1'b1;
      branch_target    = 32'h80;
      ext_stall        = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (imem_addr !== 32'h18 || redirect !== 1'b0 || bubble_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stall_freeze%0d got pc=%h r=%b c=%0d want 18 0 4", i, imem_addr,
                     redirect, bubble_cnt);
         end
      end
      ext_stall = 1'b0;
      tick();
      checks++; if (redirect !== 1'b1 || imem_addr !== 32'h80 || bubble_cnt !== 16'd5) begin
         errors++; $display("FAIL stall_release got r=%b pc=%h c=%0d want 1 80 5", redirect,
                            imem_addr, bubble_cnt); end
      clear_branch();
      tick();
      checks++; if (pc_step_1 !== 32'h80 || valid_step_1 !== 1'b1) begin errors++;
         $display("FAIL stall_resume got %h/%b want 80/1", pc_step_1, valid_step_1); end
   endtask

   task automatic test_async_reset();
      is_branch = 1'b1;
      tick();
      is_branch_step_4 = 1'b1;
      branch_taken     = 1'b1;
      branch_target    = 32'hC0;
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'h0 || pc_step_1 !== 32'h0 || valid_step_1 !== 1'b0 ||
          redirect !== 1'b0 || bubble_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset got pc=%h p1=%h v=%b r=%b c=%0d want 0 0 0 0 0",
                  imem_addr, pc_step_1, valid_step_1, redirect, bubble_cnt);
      end
      clear_branch();
      rst = 1'b1;
      tick();
      checks++;
      if (pc_step_1 !== 32'h0 || valid_step_1 !== 1'b1 || instr_step_1 !== mem(32'h0) ||
          redirect !== 1'b0 || imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL async_restart got %h/%b/%h r=%b pc=%h want 0/1/%h r=0 pc=4",
                  pc_step_1, valid_step_1, instr_step_1, redirect, imem_addr, mem(32'h0));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_taken();
      test_not_taken();
      test_saturate();
      test_stall();
      test_saturate();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
